// File: rtl/adat_frame_deframer.sv
// adat_frame_deframer
// Deframes the decoded ADAT bit stream into 256-bit frames:
//   sync (10 zeros + '1'), 4 user bits + '1', 8 channels x 6 nibbles, each nibble + '1'.
// Bits are consumed only on edges where bit_tick_ni is low and bit_valid_i is high.
// Ports:
//   clk_x4_i         x4 bit clock, only clock of the block
//   rst_i            synchronous reset, active-high, highest priority
//   bit_tick_ni      active-low bit strobe
//   bit_i            decoded data bit
//   bit_valid_i      decoder synced flag; low during a strobe forces a silent unlock
//   sample_data_o    24-bit channel sample, MSB is the first received bit
//   sample_channel_o channel index of sample_data_o
//   sample_valid_o   1-cycle pulse, sample outputs updated
//   user_bits_o      user bits of the current frame, first received bit in [3]
//   frame_start_o    1-cycle pulse when the user bits are accepted
//   locked_o         high while frame alignment is held
//   frame_error_o    1-cycle pulse on a framing violation while locked
module adat_frame_deframer #(
  parameter int unsigned SYNC_ZEROS     = 10,
  parameter int unsigned HUNT_MIN_ZEROS = 10
) (
  input  logic        clk_x4_i,
  input  logic        rst_i,
  input  logic        bit_tick_ni,
  input  logic        bit_i,
  input  logic        bit_valid_i,
  output logic [23:0] sample_data_o,
  output logic [2:0]  sample_channel_o,
  output logic        sample_valid_o,
  output logic [3:0]  user_bits_o,
  output logic        frame_start_o,
  output logic        locked_o,
  output logic        frame_error_o
);

  localparam logic [3:0] SyncZeros = 4'(SYNC_ZEROS);
  localparam logic [3:0] HuntMin   = 4'(HUNT_MIN_ZEROS);

  typedef enum logic [2:0] {
    StHunt,
    StUser,
    StUserSep,
    StNibble,
    StNibSep,
    StSync
  } state_e;

  state_e      state;
  logic [3:0]  zcnt;
  logic [2:0]  nib;
  logic [2:0]  ch;
  logic [1:0]  bcnt;   // bit position inside the current 4-bit group
  logic [23:0] acc;
  logic [3:0]  ushift;

  logic consume;
  logic drop;
  logic err;

  assign consume = ~bit_tick_ni & bit_valid_i;
  assign drop    = ~bit_tick_ni & ~bit_valid_i;

  // Framing violations: a missing separator, or a sync run of the wrong length.
  always_comb begin
    err = 1'b0;
    if (consume) begin
      case (state)
        StUserSep, StNibSep: err = ~bit_i;
        StSync:              err = bit_i ? (zcnt != SyncZeros) : (zcnt == SyncZeros);
        default:             err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_x4_i) begin
    if (rst_i) begin
      state            <= StHunt;
      zcnt             <= '0;
      nib              <= '0;
      ch               <= '0;
      bcnt             <= '0;
      acc              <= '0;
      ushift           <= '0;
      sample_data_o    <= '0;
      sample_channel_o <= '0;
      sample_valid_o   <= 1'b0;
      user_bits_o      <= '0;
      frame_start_o    <= 1'b0;
      locked_o         <= 1'b0;
      frame_error_o    <= 1'b0;
    end else begin
      sample_valid_o <= 1'b0;
      frame_start_o  <= 1'b0;
      frame_error_o  <= 1'b0;
      if (drop) begin
        // Decoder lost sync: unlock quietly, no error pulse.
        state    <= StHunt;
        locked_o <= 1'b0;
        zcnt     <= '0;
        nib      <= '0;
        ch       <= '0;
        bcnt     <= '0;
      end else if (err) begin
        state         <= StHunt;
        locked_o      <= 1'b0;
        frame_error_o <= 1'b1;
        // The offending zero already counts toward the next sync run.
        zcnt          <= bit_i ? 4'd0 : 4'd1;
        nib           <= '0;
        ch            <= '0;
        bcnt          <= '0;
      end else if (consume) begin
        case (state)
          StHunt: begin
            if (!bit_i) begin
              if (zcnt != 4'd15) zcnt <= zcnt + 4'd1;
            end else if (zcnt >= HuntMin) begin
              state    <= StUser;
              locked_o <= 1'b1;
              zcnt     <= '0;
              bcnt     <= '0;
            end else begin
              zcnt <= '0;
            end
          end
          StUser: begin
            ushift <= {ushift[2:0], bit_i};
            bcnt   <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= StUserSep;
          end
          StUserSep: begin
            user_bits_o   <= ushift;
            frame_start_o <= 1'b1;
            ch            <= '0;
            nib           <= '0;
            bcnt          <= '0;
            state         <= StNibble;
          end
          StNibble: begin
            acc  <= {acc[22:0], bit_i};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= StNibSep;
          end
          StNibSep: begin
            bcnt <= '0;
            if (nib != 3'd5) begin
              nib   <= nib + 3'd1;
              state <= StNibble;
            end else begin
              sample_data_o    <= acc;
              sample_channel_o <= ch;
              sample_valid_o   <= 1'b1;
              nib              <= '0;
              if (ch != 3'd7) begin
                ch    <= ch + 3'd1;
                state <= StNibble;
              end else begin
                state <= StSync;
                zcnt  <= '0;
              end
            end
          end
          StSync: begin
            if (bit_i) begin
              state <= StUser;
              zcnt  <= '0;
              bcnt  <= '0;
            end else begin
              zcnt <= zcnt + 4'd1;
            end
          end
          default: begin
            state    <= StHunt;
            locked_o <= 1'b0;
            zcnt     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adat_frame_deframer.sv
// Self-checking bench for adat_frame_deframer. A position-in-frame reference model predicts
// every output each cycle; directed checks cover the named scenarios.
module tb_adat_frame_deframer;

  logic        clk_x4 = 1'b0;
  logic        rst    = 1'b1;
  logic        tick_n = 1'b1;
  logic        bit_in = 1'b0;
  logic        valid  = 1'b0;
  logic [23:0] sample_data;
  logic [2:0]  sample_channel;
  logic        sample_valid;
  logic [3:0]  user_bits;
  logic        frame_start;
  logic        locked;
  logic        frame_error;

  adat_frame_deframer dut (
    .clk_x4_i        (clk_x4),
    .rst_i           (rst),
    .bit_tick_ni     (tick_n),
    .bit_i           (bit_in),
    .bit_valid_i     (valid),
    .sample_data_o   (sample_data),
    .sample_channel_o(sample_channel),
    .sample_valid_o  (sample_valid),
    .user_bits_o     (user_bits),
    .frame_start_o   (frame_start),
    .locked_o        (locked),
    .frame_error_o   (frame_error)
  );

  always #5 clk_x4 = ~clk_x4;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks bit position within a 256-bit frame after the sync '1'.
  logic        m_locked = 1'b0;
  int          m_zcnt   = 0;
  int          m_pos    = 0;
  logic [3:0]  m_ubits  = '0;
  logic [23:0] m_chd    = '0;
  logic [23:0] e_data   = '0;
  logic [2:0]  e_ch     = '0;
  logic        e_sv     = 1'b0;
  logic [3:0]  e_user   = '0;
  logic        e_fs     = 1'b0;
  logic        e_lock   = 1'b0;
  logic        e_fe     = 1'b0;

  task automatic m_consume(input logic b);
    int q, c, r, n, w;
    logic bad;
    bad = 1'b0;
    if (!m_locked) begin
      if (!b) m_zcnt = (m_zcnt < 15) ? m_zcnt + 1 : 15;
      else if (m_zcnt >= 10) begin
        m_locked = 1'b1;
        m_pos    = 0;
        m_zcnt   = 0;
      end else m_zcnt = 0;
    end else begin
      if (m_pos < 4) m_ubits[3-m_pos] = b;
      else if (m_pos == 4) begin
        if (b) begin
          e_user = m_ubits;
          e_fs   = 1'b1;
        end else bad = 1'b1;
      end else if (m_pos < 245) begin
        q = m_pos - 5;
        c = q / 30;
        r = q % 30;
        n = r / 5;
        w = r % 5;
        if (w < 4) m_chd[23-(n*4+w)] = b;
        else if (!b) bad = 1'b1;
        else if (n == 5) begin
          e_data = m_chd;
          e_ch   = 3'(c);
          e_sv   = 1'b1;
        end
      end else if (m_pos < 255) begin
        if (b) bad = 1'b1;
      end else if (!b) bad = 1'b1;
      if (bad) begin
        m_locked = 1'b0;
        e_fe     = 1'b1;
        m_zcnt   = b ? 0 : 1;
      end else m_pos = (m_pos + 1) % 256;
    end
  endtask

  initial forever begin
    @(posedge clk_x4);
    e_sv = 1'b0;
    e_fs = 1'b0;
    e_fe = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_zcnt   = 0;
      m_pos    = 0;
      e_data   = '0;
      e_ch     = '0;
      e_user   = '0;
    end else if (!tick_n) begin
      if (!valid) begin
        m_locked = 1'b0;
        m_zcnt   = 0;
      end else m_consume(bit_in);
    end
    e_lock = m_locked;
  end

  // Per-cycle comparison plus pulse counters for the directed checks.
  int n_sv = 0;
  int n_fs = 0;
  int n_fe = 0;

  initial forever begin
    @(negedge clk_x4);
    check_eq("sample_valid", 32'(sample_valid), 32'(e_sv));
    check_eq("frame_start", 32'(frame_start), 32'(e_fs));
    check_eq("frame_error", 32'(frame_error), 32'(e_fe));
    check_eq("locked", 32'(locked), 32'(e_lock));
    check_eq("user_bits", 32'(user_bits), 32'(e_user));
    check_eq("sample_data", 32'(sample_data), 32'(e_data));
    check_eq("sample_channel", 32'(sample_channel), 32'(e_ch));
    if (sample_valid === 1'b1) n_sv++;
    if (frame_start === 1'b1) n_fs++;
    if (frame_error === 1'b1) n_fe++;
  end

  // Stimulus
  logic bq[$];

  task automatic push_sync(input int nz);
    repeat (nz) bq.push_back(1'b0);
    bq.push_back(1'b1);
  endtask

  task automatic push_body(input logic [3:0] u, input bit fixed);
    logic [23:0] s;
    for (int i = 3; i >= 0; i--) bq.push_back(u[i]);
    bq.push_back(1'b1);
    for (int c = 0; c < 8; c++) begin
      s = fixed ? 24'(24'h111111 * c) : 24'($urandom);
      for (int n = 0; n < 6; n++) begin
        for (int b = 0; b < 4; b++) bq.push_back(s[23-(n*4+b)]);
        bq.push_back(1'b1);
      end
    end
  endtask

  // One bit per 4 cycles; the input pins carry noise between strobes.
  task automatic send_bit(input logic b, input logic v);
    @(negedge clk_x4);
    tick_n = 1'b0;
    bit_in = b;
    valid  = v;
    repeat (3) begin
      @(negedge clk_x4);
      tick_n = 1'b1;
      bit_in = 1'($urandom);
      valid  = 1'($urandom);
    end
  endtask

  task automatic send_q(input int drop_idx, input int limit);
    for (int i = 0; i < bq.size() && i < limit; i++) send_bit(bq[i], i != drop_idx);
    bq.delete();
  endtask

  task automatic send_all();
    send_q(-1, 1 << 30);
  endtask

  task automatic do_reset();
    @(negedge clk_x4);
    rst = 1'b1;
    repeat (2) @(negedge clk_x4);
    rst = 1'b0;
  endtask

  int sv0, fs0, fe0, base;

  initial begin
    do_reset();
    check_eq("reset_locked", 32'(locked), 32'd0);
    check_eq("reset_user", 32'(user_bits), 32'd0);

    // 1: clean frame with known content
    sv0 = n_sv; fs0 = n_fs;
    push_sync(12);
    push_body(4'hA, 1'b1);
    send_all();
    check_eq("t1_locked", 32'(locked), 32'd1);
    check_eq("t1_user", 32'(user_bits), 32'hA);
    check_eq("t1_samples", 32'(n_sv - sv0), 32'd8);
    check_eq("t1_frame_start", 32'(n_fs - fs0), 32'd1);
    check_eq("t1_last_data", 32'(sample_data), 32'h777777);
    check_eq("t1_last_ch", 32'(sample_channel), 32'd7);

    // 2: short hunt run stays unlocked, long one locks
    do_reset();
    push_sync(9);
    push_body(4'(4'($urandom)), 1'b0);
    send_all();
    check_eq("t2_short_unlocked", 32'(locked), 32'd0);
    push_sync(12);
    push_body(4'(4'($urandom)), 1'b0);
    push_sync(10);
    push_body(4'(4'($urandom)), 1'b0);
    send_all();
    check_eq("t2_long_locked", 32'(locked), 32'd1);

    // 3: ch3 nibble-2 separator forced low
    sv0 = n_sv; fe0 = n_fe;
    push_sync(10);
    base = bq.size();
    push_body(4'h5, 1'b0);
    bq[base + 5 + 3*30 + 2*5 + 4] = 1'b0;
    send_all();
    check_eq("t3_error_pulses", 32'(n_fe - fe0), 32'd1);
    check_eq("t3_samples", 32'(n_sv - sv0), 32'd3);
    check_eq("t3_unlocked", 32'(locked), 32'd0);
    push_sync(10);
    push_body(4'h3, 1'b0);
    send_all();
    check_eq("t3_relock", 32'(locked), 32'd1);

    // 4: sync runs of 11 and 9 zeros
    for (int k = 0; k < 2; k++) begin
      fe0 = n_fe;
      push_sync(k == 0 ? 11 : 9);
      push_body(4'(4'($urandom)), 1'b0);
      send_all();
      check_eq("t4_bad_sync_error", 32'(n_fe - fe0), 32'd1);
      check_eq("t4_bad_sync_unlocked", 32'(locked), 32'd0);
      push_sync(10);
      push_body(4'(4'($urandom)), 1'b0);
      send_all();
      check_eq("t4_relock", 32'(locked), 32'd1);
    end

    // 5: decoder valid dropped for one strobe mid-channel
    fe0 = n_fe;
    push_sync(10);
    base = bq.size();
    push_body(4'hC, 1'b0);
    send_q(base + 5 + 2*30 + 7, 1 << 30);
    check_eq("t5_no_error", 32'(n_fe - fe0), 32'd0);
    check_eq("t5_unlocked", 32'(locked), 32'd0);
    push_sync(10);
    push_body(4'h9, 1'b0);
    send_all();
    check_eq("t5_relock", 32'(locked), 32'd1);

    // 6: back-to-back frames, then reset mid-ch5 on a strobe edge
    sv0 = n_sv;
    repeat (3) begin
      push_sync(10);
      push_body(4'(4'($urandom)), 1'b0);
    end
    send_all();
    check_eq("t6_b2b_samples", 32'(n_sv - sv0), 32'd24);
    push_sync(10);
    base = bq.size();
    push_body(4'hF, 1'b0);
    send_q(-1, base + 5 + 5*30 + 12);
    @(negedge clk_x4);
    rst    = 1'b1;
    tick_n = 1'b0;
    bit_in = 1'b1;
    valid  = 1'b1;
    @(negedge clk_x4);
    rst    = 1'b0;
    tick_n = 1'b1;
    check_eq("t6_rst_outputs",
             {sample_data, sample_channel, sample_valid, user_bits, frame_start, locked,
              frame_error}, 32'd0);
    push_sync(10);
    push_body(4'h6, 1'b0);
    push_sync(10);
    push_body(4'h2, 1'b0);
    send_all();
    check_eq("t6_relock", 32'(locked), 32'd1);
    check_eq("t6_user", 32'(user_bits), 32'h2);

    repeat (4) @(negedge clk_x4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
